// File: rtl/stack_pop_unit.sv
// stack_pop_unit: multi-cycle POP/RET/RTI read sequencer for the descending
// data stack. Owns the stack pointer and pops 1, 2 or 3 words depending on op.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, op           request (sampled in IDLE); 00 POP, 01 RET, 10 RTI
//   sp_dec              push side consumed a word (IDLE only)
//   mem_read_data       read data, valid the cycle after mem_read_en
//   mem_read_en         read strobe
//   mem_addr            read address (SP+1 while reading, else 0)
//   sp                  current stack pointer
//   busy, done, err     stall, completion pulse, underflow flag (with done)
//   reg_data            POP result
//   pc_out, flags_out   RET/RTI results
//   reg_load, pc_load, flags_load  write enables, pulse with a clean done
module stack_pop_unit #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SP_WIDTH   = 32,
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned SP_RESET   = 2047
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic                  sp_dec,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_read_en,
  output logic [SP_WIDTH-1:0]   mem_addr,
  output logic [SP_WIDTH-1:0]   sp,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] reg_data,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [2:0]            flags_out,
  output logic                  reg_load,
  output logic                  pc_load,
  output logic                  flags_load
);

  localparam logic [1:0] OP_POP = 2'b00;
  localparam logic [1:0] OP_RET = 2'b01;
  localparam logic [1:0] OP_RTI = 2'b10;
  localparam logic [SP_WIDTH-1:0] SP_EMPTY = SP_WIDTH'(SP_RESET);

  typedef enum logic [1:0] {IDLE, RD, CAP, FIN} state_t;

  state_t                state_q, state_n;
  logic [1:0]            op_q, op_n;
  logic [1:0]            cnt_q, cnt_n;
  logic [SP_WIDTH-1:0]   sp_n;
  logic [DATA_WIDTH-1:0] w0_q, w0_n, w1_q, w1_n;
  logic [DATA_WIDTH-1:0] reg_data_n;
  logic [PC_WIDTH-1:0]   pc_n;
  logic [2:0]            flags_n;
  logic                  err_n, done_n;
  logic [1:0]            need_q;

  // Words popped by each op.
  function automatic logic [1:0] words(input logic [1:0] o);
    case (o)
      OP_POP:  words = 2'd1;
      OP_RET:  words = 2'd2;
      default: words = 2'd3;
    endcase
  endfunction

  assign need_q = words(op_q);

  // Next-state, next-SP and result capture.
  always_comb begin
    state_n    = state_q;
    op_n       = op_q;
    cnt_n      = cnt_q;
    sp_n       = sp;
    w0_n       = w0_q;
    w1_n       = w1_q;
    reg_data_n = reg_data;
    pc_n       = pc_out;
    flags_n    = flags_out;
    err_n      = 1'b0;
    case (state_q)
      IDLE: begin
        // sp_dec lands first so the underflow check sees the decremented SP.
        if (sp_dec && (sp != '0)) sp_n = sp - SP_WIDTH'(1);
        if (start && (op != 2'b11)) begin
          op_n  = op;
          cnt_n = 2'd0;
          if (SP_WIDTH'(words(op)) > (SP_EMPTY - sp_n)) begin
            state_n = FIN;
            err_n   = 1'b1;
          end else begin
            state_n = RD;
          end
        end
      end
      RD: begin
        sp_n    = sp + SP_WIDTH'(1);
        state_n = CAP;
      end
      CAP: begin
        cnt_n = cnt_q + 2'd1;
        if (cnt_q == 2'd0) w0_n = mem_read_data;
        if (cnt_q == 2'd1) w1_n = mem_read_data;
        if (cnt_q == need_q - 2'd1) begin
          state_n = FIN;
          cnt_n   = 2'd0;
          // Results update on entry to FIN so they are visible with done.
          case (op_q)
            OP_POP:  reg_data_n = mem_read_data;
            OP_RET:  pc_n = PC_WIDTH'({mem_read_data, w0_q});
            default: begin
              pc_n    = PC_WIDTH'({w1_q, w0_q});
              flags_n = mem_read_data[2:0];
            end
          endcase
        end else begin
          state_n = RD;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    done_n = (state_n == FIN);
  end

  // State register and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_POP;
      cnt_q       <= 2'd0;
      w0_q        <= '0;
      w1_q        <= '0;
      sp          <= SP_EMPTY;
      mem_read_en <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      reg_data    <= '0;
      pc_out      <= '0;
      flags_out   <= 3'd0;
      reg_load    <= 1'b0;
      pc_load     <= 1'b0;
      flags_load  <= 1'b0;
    end else begin
      state_q     <= state_n;
      op_q        <= op_n;
      cnt_q       <= cnt_n;
      w0_q        <= w0_n;
      w1_q        <= w1_n;
      sp          <= sp_n;
      mem_read_en <= (state_n == RD);
      mem_addr    <= (state_n == RD) ? sp_n + SP_WIDTH'(1) : '0;
      busy        <= (state_n != IDLE);
      done        <= done_n;
      err         <= err_n;
      reg_data    <= reg_data_n;
      pc_out      <= pc_n;
      flags_out   <= flags_n;
      reg_load    <= done_n && !err_n && (op_n == OP_POP);
      pc_load     <= done_n && !err_n && ((op_n == OP_RET) || (op_n == OP_RTI));
      flags_load  <= done_n && !err_n && (op_n == OP_RTI);
    end
  end

endmodule

// File: tb/tb_stack_pop_unit.sv
// Scoreboard bench for stack_pop_unit: stimulus queues expected completions
// and read addresses; a negedge monitor checks them as the DUT presents them.
module tb_stack_pop_unit;

  logic        clk, reset, start, sp_dec;
  logic [1:0]  op;
  logic [15:0] mem_read_data;
  logic        mem_read_en, busy, done, err, reg_load, pc_load, flags_load;
  logic [31:0] mem_addr, sp, pc_out;
  logic [15:0] reg_data;
  logic [2:0]  flags_out;

  stack_pop_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .sp_dec(sp_dec),
    .mem_read_data(mem_read_data), .mem_read_en(mem_read_en),
    .mem_addr(mem_addr), .sp(sp), .busy(busy), .done(done), .err(err),
    .reg_data(reg_data), .pc_out(pc_out), .flags_out(flags_out),
    .reg_load(reg_load), .pc_load(pc_load), .flags_load(flags_load)
  );

  typedef struct {
    logic [86:0] resp;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  logic [15:0] mem [0:2047];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        prev_re = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: registered read, data valid the cycle after mem_read_en.
  always @(posedge clk) if (mem_read_en) mem_read_data <= mem[mem_addr[10:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: read addresses, no back-to-back reads, completion responses.
  always @(negedge clk) begin
    if (mem_read_en === 1'b1) begin
      checks++;
      if (prev_re) begin
        failures++;
        $display("FAIL read_b2b actual=1 required=0 at cyc %0d", cyc);
      end
      if (addr_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read actual=%0d required=none", mem_addr);
      end else begin
        logic [31:0] a;
        a = addr_q.pop_front();
        chk("read_addr", 64'(mem_addr), 64'(a));
      end
    end
    prev_re = (mem_read_en === 1'b1);
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 at cyc %0d", cyc);
      end else begin
        exp_t e;
        logic [86:0] act;
        e   = exp_q.pop_front();
        act = {err, reg_load, pc_load, flags_load, reg_data, pc_out, flags_out, sp};
        checks++;
        if (act !== e.resp) begin
          failures++;
          $display("FAIL done_resp actual=%h required=%h", act, e.resp);
        end
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  function automatic logic [86:0] mk(input logic e, input logic rl, input logic pl,
                                     input logic fl, input logic [15:0] rd,
                                     input logic [31:0] pc, input logic [2:0] f,
                                     input logic [31:0] s);
    return {e, rl, pl, fl, rd, pc, f, s};
  endfunction

  task automatic do_dec(input int n);
    repeat (n) begin
      sp_dec = 1'b1;
      @(negedge clk);
      sp_dec = 1'b0;
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [86:0] resp, input int lat);
    exp_t e;
    e.resp = resp;
    e.cyc  = cyc + lat;
    exp_q.push_back(e);
    start = 1'b1;
    op    = o;
    @(negedge clk);
    start  = 1'b0;
    sp_dec = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=pending required=done");
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
    reset = 1'b1; start = 1'b0; op = 2'b00; sp_dec = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state.
    chk("reset_sp", 64'(sp), 64'd2047);
    chk("reset_ctl", 64'({busy, done, err, mem_read_en, reg_load, pc_load, flags_load}), 64'd0);
    chk("reset_data", 64'({reg_data, pc_out, flags_out}), 64'd0);
    chk("reset_addr", 64'(mem_addr), 64'd0);

    // Reserved op is ignored.
    start = 1'b1; op = 2'b11;
    @(negedge clk);
    start = 1'b0;
    chk("op11_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("op11_idle", 64'({busy, done, mem_read_en}), 64'd0);

    // POP one word.
    mem[2047] = 16'hBEEF;
    do_dec(1);
    chk("dec_sp", 64'(sp), 64'd2046);
    addr_q.push_back(32'd2047);
    issue(2'b00, mk(0, 1, 0, 0, 16'hBEEF, 32'h0, 3'd0, 32'd2047), 3);
    wait_done();

    // RTI three words.
    do_dec(3);
    chk("dec3_sp", 64'(sp), 64'd2044);
    mem[2045] = 16'h5678; mem[2046] = 16'h1234; mem[2047] = 16'h0005;
    addr_q.push_back(32'd2045); addr_q.push_back(32'd2046); addr_q.push_back(32'd2047);
    issue(2'b10, mk(0, 0, 1, 1, 16'hBEEF, 32'h12345678, 3'b101, 32'd2047), 7);
    wait_done();

    // RET underflow with only one word available.
    do_dec(1);
    issue(2'b01, mk(1, 0, 0, 0, 16'hBEEF, 32'h12345678, 3'b101, 32'd2046), 1);
    wait_done();
    chk("err_sp_kept", 64'(sp), 64'd2046);

    // RET two words.
    do_dec(1);
    mem[2046] = 16'h9ABC; mem[2047] = 16'hDEF0;
    addr_q.push_back(32'd2046); addr_q.push_back(32'd2047);
    issue(2'b01, mk(0, 0, 1, 0, 16'hBEEF, 32'hDEF09ABC, 3'b101, 32'd2047), 5);
    wait_done();

    // start with sp_dec in the same cycle; start/sp_dec while busy ignored.
    mem[2047] = 16'h4321;
    sp_dec = 1'b1;
    addr_q.push_back(32'd2047);
    issue(2'b00, mk(0, 1, 0, 0, 16'h4321, 32'hDEF09ABC, 3'b101, 32'd2047), 3);
    start = 1'b1; op = 2'b10; sp_dec = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0; sp_dec = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("busy_ignored_sp", 64'(sp), 64'd2047);

    // POP on an empty stack.
    issue(2'b00, mk(1, 0, 0, 0, 16'h4321, 32'hDEF09ABC, 3'b101, 32'd2047), 1);
    wait_done();

    // SP saturates at 0.
    do_dec(2048);
    chk("sp_no_wrap", 64'(sp), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("sp_after_reset", 64'(sp), 64'd2047);

    // Reset in cycle 3 of a RET discards it with no done.
    do_dec(2);
    addr_q.push_back(32'd2046); addr_q.push_back(32'd2047);
    start = 1'b1; op = 2'b01;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_idle", 64'({busy, done, mem_read_en}), 64'd0);
    chk("abort_sp", 64'(sp), 64'd2047);
    chk("abort_pc", 64'(pc_out), 64'd0);
    repeat (8) @(negedge clk);

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
